// File: rtl/rsa_pkg.sv
// Shared definitions for the Montgomery constant calculator.
package rsa_pkg;

  // Controller states: waiting, iterating, result-valid pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of doubling iterations needed to reach R^2 = 2^(2*(width+2)).
  function automatic int calc_iters(input int width);
    return 2 * (width + 2);
  endfunction

endpackage

// File: rtl/mod_double_unit.sv
// Combinational conditional-double step: r_next = (2r >= m) ? 2r - m : 2r.
module mod_double_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r_next
);
  import rsa_pkg::*;

  logic [WIDTH:0] t;
  logic [WIDTH:0] m_ext;

  // Double r in a WIDTH+1 bit field so the carry out is never lost.
  always_comb begin
    t      = {r, 1'b0};
    m_ext  = {1'b0, m};
    r_next = t[WIDTH-1:0];
    if (t >= m_ext) begin
      r_next = WIDTH'(t - m_ext);
    end else begin
      r_next = t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/rsa_const_calc.sv
// Computes Const = R^2 mod M (R = 2^(WIDTH+2)) by repeated modular doubling of 1.
module rsa_const_calc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import rsa_pkg::*;

  localparam int N     = calc_iters(WIDTH);
  localparam int CNT_W = $clog2(N + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dbl_r;

  mod_double_unit #(.WIDTH(WIDTH)) u_dbl (
    .r      (r_q),
    .m      (m_q),
    .r_next (dbl_r)
  );

  // Next-state and datapath update; everything holds unless the FSM says otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    m_d     = m_q;
    const_d = const_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = M;
          r_d     = (M == WIDTH'(1)) ? {WIDTH{1'b0}} : WIDTH'(1);
          cnt_d   = {CNT_W{1'b0}};
          err_d   = ~M[0];
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = dbl_r;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          // Even or zero modulus has no valid Montgomery constant.
          const_d = err_q ? {WIDTH{1'b0}} : dbl_r;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; ena low freezes everything including done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      const_q <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      m_q     <= m_d;
      const_q <= const_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Const = const_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_const_calc.sv
// Self-checking bench for rsa_const_calc (WIDTH=8): vector table, corner sequences, random moduli.
module tb_rsa_const_calc;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       start;
  logic [7:0] M;
  logic [7:0] const_out;
  logic       busy;
  logic       done;
  logic       err;

  int tests;
  int fails;
  logic [7:0] last_const;

  rsa_const_calc #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .start (start),
    .M     (M),
    .Const (const_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m;
    logic [7:0] c;
    logic       e;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: 2^20 mod m for odd m, zero with error flag otherwise.
  function automatic logic [7:0] ref_const(input logic [7:0] m);
    longint unsigned p;
    if (m[0] == 1'b0) return 8'h00;
    p = 64'd1 << 20;
    return 8'(p % longint'(m));
  endfunction

  // One computation. junk: start pulses and M change mid-run; stall_at: ena low 5 cycles;
  // hold_done: keep ena low while done is up and verify it stretches.
  task automatic run_calc(input logic [7:0] m, input logic [7:0] exp_c, input logic exp_e,
                          input int exp_lat, input int stall_at, input bit junk, input bit hold_done);
    int edges;
    int busy_cnt;
    int guard;
    @(negedge clk);
    M = m; start = 1'b1; ena = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    start = 1'b0;
    M = 8'h00;
    busy_cnt = busy ? 1 : 0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    guard = 0;
    while (!done && guard < 100) begin
      if (stall_at > 0 && edges >= stall_at && edges < stall_at + 5) ena = 1'b0;
      else ena = 1'b1;
      if (junk && edges == 5) begin start = 1'b1; M = 8'h0D; end
      if (junk && edges == 7) start = 1'b0;
      @(posedge clk);
      edges++;
      guard++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (edges == 3) check("const_hold_in_run", {24'd0, const_out}, {24'd0, last_const});
    end
    start = 1'b0;
    ena = 1'b1;
    check("done_seen", {31'd0, done}, 32'd1);
    check("done_latency", edges, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat + 1);
    check("const_value", {24'd0, const_out}, {24'd0, exp_c});
    check("err_value", {31'd0, err}, {31'd0, exp_e});
    if (hold_done) begin
      ena = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("done_stretch", {31'd0, done}, 32'd1);
      check("busy_stretch", {31'd0, busy}, 32'd1);
      ena = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("no_second_done", {31'd0, done}, 32'd0);
    check("const_held", {24'd0, const_out}, {24'd0, exp_c});
    check("err_held", {31'd0, err}, {31'd0, exp_e});
    last_const = exp_c;
  endtask

  initial begin
    int done_hits;
    logic [7:0] rm;
    tests = 0;
    fails = 0;
    last_const = 8'h00;

    vecs[0] = '{m: 8'hFB, c: 8'h95, e: 1'b0};
    vecs[1] = '{m: 8'h0D, c: 8'h09, e: 1'b0};
    vecs[2] = '{m: 8'h01, c: 8'h00, e: 1'b0};
    vecs[3] = '{m: 8'h10, c: 8'h00, e: 1'b1};
    vecs[4] = '{m: 8'hFB, c: 8'h95, e: 1'b0};
    vecs[5] = '{m: 8'hFF, c: 8'h10, e: 1'b0};
    vecs[6] = '{m: 8'h81, c: 8'h40, e: 1'b0};
    vecs[7] = '{m: 8'h00, c: 8'h00, e: 1'b1};

    rst = 1'b1; ena = 1'b0; start = 1'b0; M = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_const", {24'd0, const_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    ena = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_calc(vecs[i].m, vecs[i].c, vecs[i].e, 20, 0, 1'b0, 1'b0);
    end

    // Start pulses and M change during RUN are ignored.
    run_calc(8'hFB, 8'h95, 1'b0, 20, 0, 1'b1, 1'b0);
    // ena low for five cycles mid-run.
    run_calc(8'hFB, 8'h95, 1'b0, 25, 8, 1'b0, 1'b0);
    // done stretches while ena is low.
    run_calc(8'h0D, 8'h09, 1'b0, 20, 0, 1'b0, 1'b1);
    // Switch Const to a nonzero value before the reset test.
    run_calc(8'hFB, 8'h95, 1'b0, 20, 0, 1'b0, 1'b0);

    // Reset at iteration 10 aborts without done.
    @(negedge clk);
    M = 8'hFB; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_const", {24'd0, const_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_hits = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) done_hits++;
    end
    check("rst_no_done", done_hits, 0);
    last_const = 8'h00;
    run_calc(8'h0D, 8'h09, 1'b0, 20, 0, 1'b0, 1'b0);

    // Random moduli against the arithmetic reference.
    for (int j = 0; j < 20; j++) begin
      rm = 8'($urandom_range(0, 255));
      run_calc(rm, ref_const(rm), ~rm[0], 20, 0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsa_const_calc.md
RSA_CONST_CALC -- requirements
Module: rsa_const_calc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; internal Montgomery width is WIDTH+2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ena, input, 1 bit: clock enable; while low, all state holds.
REQ-005 SHALL have port start, input, 1 bit: request to compute Const for the modulus on M.
REQ-006 SHALL have port M, input, WIDTH bits: the modulus, sampled only on an accepted start.
REQ-007 SHALL have port Const, output, WIDTH bits: R^2 mod M, where R = 2^(WIDTH+2); this value feeds the RSA datapath Const input.
REQ-008 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-009 SHALL have port done, output, 1 bit: a single-cycle pulse marking Const valid.
REQ-010 SHALL have port err, output, 1 bit: high when the latched M is even or zero; holds until the next accepted start.

Function
REQ-011 SHALL use the states IDLE, RUN and DONE.
REQ-012 IDLE: start=1 with ena=1 is accepted at that edge.
- Latches M into m_q.
- Loads r to 0 if M==1, else to 1.
- Clears iteration count to 0 and err to 0.
- Moves to RUN.
REQ-013 err SHALL be set at acceptance if M[0]==0; the computation still runs to completion, but Const is loaded as 0.
REQ-014 RUN: each enabled edge performs one iteration, t = 2*r (WIDTH+1 bits), then r <= (t >= m_q) ? t - m_q : t, and increments the count.
REQ-015 Iteration count N SHALL be 2*(WIDTH+2), which is 20 for WIDTH=8; the count register is wide enough to hold N.
REQ-016 At the enabled edge performing iteration N, the block SHALL load Const with the final r (or 0 if err) and move to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then move to IDLE on the next enabled edge.
- done therefore rises N edges after the accepting edge.
- Total start-to-IDLE is N+2 edges when ena is held high.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 start in RUN or DONE SHALL be ignored; M changes after acceptance SHALL have no effect.
REQ-020 With ena low, state, count, r, Const, err and the done level SHALL all hold.
- A done pulse therefore stretches while ena is low.
REQ-021 Const SHALL hold its last value between computations and change only at the REQ-016 edge.
REQ-022 All arithmetic is unsigned; r < m_q holds after every iteration for odd M > 1.

Reset
REQ-023 On rst high the block SHALL asynchronously enter IDLE with: count=0, r=0, m_q=0, Const=0, busy=0, done=0, err=0.
REQ-024 Reset asserted mid-RUN SHALL abort the computation with no done pulse; the first enabled edge after deassertion is treated as IDLE.

Structure
REQ-025 A shared package rsa_pkg SHALL hold:
- the state enum type (IDLE/RUN/DONE);
- a constant function returning N = 2*(WIDTH+2).
REQ-026 The conditional-double step (t=2r; subtract m_q if t>=m_q) SHALL be a separate combinational sub-module, mod_double_unit, parameterised by WIDTH.
REQ-027 All registers SHALL live in rsa_const_calc; mod_double_unit has no state.

Verification
REQ-028 WIDTH=8, M=0xFB, start pulse, ena=1 -> done exactly 20 edges after acceptance; Const=0x95; err=0; busy high for 21 cycles.
REQ-029 M=0x0D -> Const=0x09, err=0; M=0x01 -> Const=0x00, err=0.
REQ-030 M=0x10 (even) -> done after 20 edges, Const=0x00, err=1; a following start with M=0xFB clears err and gives Const=0x95.
REQ-031 Start pulses and an M change to 0x0D during RUN -> ignored; result is still 0x95 for the originally latched 0xFB; only one done pulse.
REQ-032 ena low for 5 cycles mid-RUN -> state and r frozen; done arrives 25 edges after acceptance with Const=0x95.
REQ-033 rst pulsed at iteration 10 -> all outputs 0 immediately with no done; a new start with M=0x0D completes normally with Const=0x09.
